// File: rtl/fft64_stage_sequencer.sv
// fft64_stage_sequencer
// Control sequencer for a 64-point radix-4 in-place FFT. It runs 3 stages of
// 16 butterflies. For each butterfly it issues 4 data addresses and 3 twiddle
// ROM indices. Before starting the next stage it waits for all 16 writebacks
// of the current stage, so in-place data is never read before it is written.
//
// Twiddle ROM layout: entry 0 = 1; entries 16+k, 32+k, 48+k = W64^k, W64^2k,
// W64^3k for k = 0..15.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   start                 begin a transform; sampled only in IDLE
//   abort                 return to IDLE next cycle from any state, no done
//   bf_valid / bf_ready   butterfly command handshake
//   stage, bf_idx         current stage (0..2) and butterfly index (0..15)
//   addr0..addr3          data addresses of the 4 butterfly legs
//   tw1..tw3              twiddle ROM indices of legs 1..3 (leg 0 is unit)
//   wb_valid              one pulse per butterfly result written back
//   busy                  high in every state except IDLE
//   done                  one-cycle pulse when a transform completes
//   err                   sticky error: writeback overflow or drain timeout

module fft64_stage_sequencer #(
  parameter int unsigned DRAIN_TIMEOUT = 255,
  parameter int unsigned WB_CNT_W      = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       bf_valid,
  input  logic       bf_ready,
  output logic [1:0] stage,
  output logic [3:0] bf_idx,
  output logic [5:0] addr0,
  output logic [5:0] addr1,
  output logic [5:0] addr2,
  output logic [5:0] addr3,
  output logic [5:0] tw1,
  output logic [5:0] tw2,
  output logic [5:0] tw3,
  input  logic       wb_valid,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned TMO_W = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [WB_CNT_W-1:0] WB_FULL    = WB_CNT_W'(16);
  localparam logic [WB_CNT_W-1:0] WB_LAST    = WB_CNT_W'(15);
  localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(DRAIN_TIMEOUT - 1);
  localparam logic [1:0]          LAST_STAGE = 2'd2;
  localparam logic [3:0]          LAST_BF    = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [WB_CNT_W-1:0] wb_count;
  logic [TMO_W-1:0]    tmo_cnt;

  logic accept_start;
  logic handshake;
  logic last_bf;
  logic wb_full;
  logic drain_done;
  logic wb_overflow;
  logic tmo_expire;

  // Cycle events shared by the FSM and the counters
  assign accept_start = (state == S_IDLE) && start;
  assign handshake    = (state == S_ISSUE) && bf_ready;
  assign last_bf      = handshake && (bf_idx == LAST_BF);
  assign wb_full      = (wb_count == WB_FULL);
  // Look ahead by one writeback so the next stage issues the cycle after the
  // 16th writeback arrives.
  assign drain_done   = (state == S_DRAIN) &&
                        (wb_full || (wb_valid && (wb_count == WB_LAST)));
  assign wb_overflow  = wb_valid && ((state == S_IDLE) || wb_full);
  assign tmo_expire   = (state == S_DRAIN) && !drain_done && !wb_valid &&
                        (tmo_cnt == TMO_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; abort overrides every other event
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) state_next = S_ISSUE;
        end
        S_ISSUE: begin
          if (last_bf) state_next = S_DRAIN;
        end
        S_DRAIN: begin
          if (drain_done) begin
            state_next = (stage == LAST_STAGE) ? S_DONE : S_ISSUE;
          end else if (tmo_expire) begin
            state_next = S_IDLE;
          end
        end
        S_DONE: begin
          state_next = S_IDLE;
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    bf_valid = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE:  ;
      S_ISSUE: begin
        bf_valid = 1'b1;
        busy     = 1'b1;
      end
      S_DRAIN: begin
        busy = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Butterfly leg addresses and twiddle indices from the registered position.
  // g = b>>2 selects the group, j = b&3 the position inside it; each field is
  // placed by concatenation so no sum can overflow.
  always_comb begin
    addr0 = 6'd0;
    addr1 = 6'd0;
    addr2 = 6'd0;
    addr3 = 6'd0;
    tw1   = 6'd0;
    tw2   = 6'd0;
    tw3   = 6'd0;
    if (state == S_ISSUE) begin
      case (stage)
        2'd0: begin
          addr0 = {2'd0, bf_idx};
          addr1 = {2'd1, bf_idx};
          addr2 = {2'd2, bf_idx};
          addr3 = {2'd3, bf_idx};
          tw1   = {2'd1, bf_idx};
          tw2   = {2'd2, bf_idx};
          tw3   = {2'd3, bf_idx};
        end
        2'd1: begin
          addr0 = {bf_idx[3:2], 2'd0, bf_idx[1:0]};
          addr1 = {bf_idx[3:2], 2'd1, bf_idx[1:0]};
          addr2 = {bf_idx[3:2], 2'd2, bf_idx[1:0]};
          addr3 = {bf_idx[3:2], 2'd3, bf_idx[1:0]};
          tw1   = {2'd1, bf_idx[1:0], 2'd0};
          tw2   = {2'd2, bf_idx[1:0], 2'd0};
          tw3   = {2'd3, bf_idx[1:0], 2'd0};
        end
        2'd2: begin
          // Last stage: contiguous quads, all twiddles are unity (entry 0)
          addr0 = {bf_idx, 2'd0};
          addr1 = {bf_idx, 2'd1};
          addr2 = {bf_idx, 2'd2};
          addr3 = {bf_idx, 2'd3};
        end
        default: ;
      endcase
    end
  end

  // Position, writeback, timeout counters and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage    <= 2'd0;
      bf_idx   <= 4'd0;
      wb_count <= '0;
      tmo_cnt  <= '0;
      err      <= 1'b0;
    end else if (abort) begin
      // err deliberately left untouched
      stage    <= 2'd0;
      bf_idx   <= 4'd0;
      wb_count <= '0;
      tmo_cnt  <= '0;
    end else begin
      if (accept_start) begin
        err <= 1'b0;
      end else if (wb_overflow || tmo_expire) begin
        err <= 1'b1;
      end

      if (accept_start) begin
        stage  <= 2'd0;
        bf_idx <= 4'd0;
      end else if (handshake) begin
        bf_idx <= bf_idx + 4'd1;
      end else if (drain_done) begin
        bf_idx <= 4'd0;
        if (stage != LAST_STAGE) stage <= stage + 2'd1;
      end else if (tmo_expire || (state == S_DONE)) begin
        stage  <= 2'd0;
        bf_idx <= 4'd0;
      end

      // Count held at 16 through DONE so a stray writeback there flags err
      if (state == S_IDLE) begin
        wb_count <= '0;
      end else if (drain_done) begin
        wb_count <= (stage == LAST_STAGE) ? WB_FULL : '0;
      end else if (tmo_expire || (state == S_DONE)) begin
        wb_count <= '0;
      end else if (wb_valid && !wb_full) begin
        wb_count <= wb_count + WB_CNT_W'(1);
      end

      if ((state != S_DRAIN) || wb_valid || drain_done || tmo_expire) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fft64_stage_sequencer.sv
// Testbench for fft64_stage_sequencer: randomized backpressure and scheduled
// writebacks, every issued command compared against an arithmetic model of
// the radix-4 FFT index pattern.
module tb_fft64_stage_sequencer;

  localparam int unsigned DRAIN_TIMEOUT = 255;
  localparam int          WB_LAT        = 2;
  localparam int          NOMINAL_BUSY  = 3 * (16 + WB_LAT) + 1;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       bf_valid;
  logic       bf_ready;
  logic [1:0] stage;
  logic [3:0] bf_idx;
  logic [5:0] addr0, addr1, addr2, addr3;
  logic [5:0] tw1, tw2, tw3;
  logic       wb_valid;
  logic       busy;
  logic       done;
  logic       err;

  fft64_stage_sequencer #(
    .DRAIN_TIMEOUT(DRAIN_TIMEOUT),
    .WB_CNT_W     (5)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .bf_valid(bf_valid),
    .bf_ready(bf_ready),
    .stage   (stage),
    .bf_idx  (bf_idx),
    .addr0   (addr0),
    .addr1   (addr1),
    .addr2   (addr2),
    .addr3   (addr3),
    .tw1     (tw1),
    .tw2     (tw2),
    .tw3     (tw3),
    .wb_valid(wb_valid),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int hs_cnt       = 0;
  int done_cnt     = 0;
  int busy_cyc     = 0;
  int hold_idx     = -1;
  int hold_len     = 0;
  int wb_q[$];
  int seen[48];
  bit auto_wb      = 1'b1;
  bit rand_ready   = 1'b0;
  bit last_done    = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: radix-4 DIF on 64 points. Stage s splits into groups of
  // 64/4^s points; butterfly legs are spaced 16/4^s apart and leg k uses
  // twiddle W64^(k*m), m = (position in group) * 4^s, stored at 16k+m.
  // The last stage has only unit twiddles (ROM entry 0).
  function automatic logic [41:0] ref_cmd(input int s, input int b);
    int base, stride, m;
    int a0, a1, a2, a3, t1, t2, t3;
    case (s)
      0:       begin base = b;                      stride = 16; m = b;           end
      1:       begin base = 16 * (b / 4) + (b % 4); stride = 4;  m = 4 * (b % 4); end
      default: begin base = 4 * b;                  stride = 1;  m = 0;           end
    endcase
    a0 = base;
    a1 = base + stride;
    a2 = base + 2 * stride;
    a3 = base + 3 * stride;
    t1 = (s == 2) ? 0 : 16 + m;
    t2 = (s == 2) ? 0 : 32 + m;
    t3 = (s == 2) ? 0 : 48 + m;
    return {6'(a0), 6'(a1), 6'(a2), 6'(a3), 6'(t1), 6'(t2), 6'(t3)};
  endfunction

  function automatic logic [41:0] cmd_now();
    return {addr0, addr1, addr2, addr3, tw1, tw2, tw3};
  endfunction

  // One clock: score a handshake, advance, check stability, drive inputs
  task automatic step();
    bit          hs, stall, has_spot;
    logic [47:0] pre;
    logic [41:0] exp_cmd, spot;
    int          due;
    hs    = (bf_valid === 1'b1) && (bf_ready === 1'b1) && !abort && !rst;
    stall = (bf_valid === 1'b1) && (bf_ready === 1'b0) && !abort && !rst;
    pre   = {stage, bf_idx, cmd_now()};
    if (hs) begin
      tests_run++;
      if (stage !== 2'(hs_cnt / 16) || bf_idx !== 4'(hs_cnt % 16)) begin
        tests_failed++;
        $display("FAIL order: got stage=%0d b=%0d, want stage=%0d b=%0d",
                 stage, bf_idx, hs_cnt / 16, hs_cnt % 16);
      end
      tests_run++;
      exp_cmd = ref_cmd(int'(stage), int'(bf_idx));
      if (cmd_now() !== exp_cmd) begin
        tests_failed++;
        $display("FAIL cmd s%0d b%0d: got %h, want %h", stage, bf_idx, cmd_now(), exp_cmd);
      end
      has_spot = 1'b1;
      spot     = '0;
      case ({stage, bf_idx})
        6'h05:   spot = {6'd5, 6'd21, 6'd37, 6'd53, 6'd21, 6'd37, 6'd53};
        6'h16:   spot = {6'd18, 6'd22, 6'd26, 6'd30, 6'd24, 6'd40, 6'd56};
        6'h27:   spot = {6'd28, 6'd29, 6'd30, 6'd31, 6'd0, 6'd0, 6'd0};
        default: has_spot = 1'b0;
      endcase
      if (has_spot) begin
        tests_run++;
        if (cmd_now() !== spot) begin
          tests_failed++;
          $display("FAIL spot s%0d b%0d: got %h, want %h", stage, bf_idx, cmd_now(), spot);
        end
      end
      if (stage != 2'd3) seen[int'(stage) * 16 + int'(bf_idx)]++;
      if (auto_wb) begin
        due = (hs_cnt == hold_idx) ? cyc + hold_len : cyc + WB_LAT;
        wb_q.push_back(due);
      end
      hs_cnt++;
    end
    last_done = done;
    @(posedge clk);
    #1;
    cyc++;
    if (busy) busy_cyc++;
    if (done) done_cnt++;
    if (stall) begin
      tests_run++;
      if ({bf_valid, stage, bf_idx, cmd_now()} !== {1'b1, pre}) begin
        tests_failed++;
        $display("FAIL stall_stable: got %h, want %h",
                 {bf_valid, stage, bf_idx, cmd_now()}, {1'b1, pre});
      end
    end
    wb_valid = 1'b0;
    if (wb_q.size() > 0 && wb_q[0] == cyc) begin
      wb_valid = 1'b1;
      void'(wb_q.pop_front());
    end
    bf_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic new_run();
    hs_cnt   = 0;
    done_cnt = 0;
    busy_cyc = 0;
    foreach (seen[i]) seen[i] = 0;
    wb_q.delete();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic finish_run(input int exp_busy);
    bit idle;
    int bad;
    idle = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      step();
      if (!busy) begin
        idle = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!idle) begin
      tests_failed++;
      $display("FAIL run_timeout: busy=%0d, want 0 within 3000 cycles", busy);
    end
    tests_run++;
    if (last_done !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_fall: done before=%0d now=%0d, want 1 then 0", last_done, done);
    end
    tests_run++;
    if (hs_cnt !== 48) begin
      tests_failed++;
      $display("FAIL hs_count: got %0d, want 48", hs_cnt);
    end
    tests_run++;
    if (done_cnt !== 1) begin
      tests_failed++;
      $display("FAIL done_pulses: got %0d, want 1", done_cnt);
    end
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++;
      $display("FAIL run_err: got %0d, want 0", err);
    end
    bad = 0;
    foreach (seen[i]) if (seen[i] != 1) bad++;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL scoreboard: %0d butterflies not issued exactly once, want 0", bad);
    end
    if (exp_busy >= 0) begin
      tests_run++;
      if (busy_cyc !== exp_busy) begin
        tests_failed++;
        $display("FAIL latency: busy for %0d cycles, want %0d", busy_cyc, exp_busy);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; bf_ready = 1'b1; wb_valid = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if ({bf_valid, busy, done, err} !== 4'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b, want 0000", {bf_valid, busy, done, err});
    end
    tests_run++;
    if ({stage, bf_idx} !== 6'd0) begin
      tests_failed++;
      $display("FAIL reset_pos: got stage=%0d b=%0d, want 0 0", stage, bf_idx);
    end
    tests_run++;
    if (cmd_now() !== 42'd0) begin
      tests_failed++;
      $display("FAIL reset_cmd: got %h, want 0", cmd_now());
    end
    rst = 1'b0;
    repeat (3) step();
    tests_run++;
    if (busy !== 1'b0 || bf_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_hold: busy=%0d bf_valid=%0d, want 0 0", busy, bf_valid);
    end
  endtask

  task automatic test_reset_mid_issue();
    bit found;
    found = 1'b0;
    new_run();
    for (int i = 0; i < 200; i++) begin
      if (bf_valid && stage == 2'd1 && bf_idx == 4'd5) begin
        found = 1'b1;
        break;
      end
      step();
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL reach_s1b5: stage=%0d b=%0d, want 1 5", stage, bf_idx);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if ({bf_valid, stage, bf_idx, cmd_now(), busy, done} !== 51'd0) begin
      tests_failed++;
      $display("FAIL async_reset: got %h, want 0", {bf_valid, stage, bf_idx, cmd_now(), busy, done});
    end
    wb_q.delete();
    wb_valid = 1'b0;
    step();
    rst = 1'b0;
    repeat (4) step();
    tests_run++;
    if (busy !== 1'b0 || bf_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_idle: busy=%0d bf_valid=%0d, want 0 0", busy, bf_valid);
    end
    new_run();
    finish_run(NOMINAL_BUSY);
  endtask

  task automatic test_nominal();
    new_run();
    finish_run(NOMINAL_BUSY);
  endtask

  task automatic test_backpressure();
    rand_ready = 1'b1;
    bf_ready   = 1'($urandom_range(0, 1));
    new_run();
    finish_run(-1);
    rand_ready = 1'b0;
    bf_ready   = 1'b1;
  endtask

  task automatic test_drain_gating();
    int bad, waited;
    hold_idx = 15;
    hold_len = 50;
    new_run();
    for (int i = 0; i < 100 && hs_cnt < 16; i++) step();
    bad    = 0;
    waited = 0;
    // Wait until the withheld 16th writeback is the one being driven
    while (!(wb_valid && wb_q.size() == 0) && waited < 80) begin
      if (stage !== 2'd0 || bf_valid !== 1'b0) bad++;
      step();
      waited++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL drain_hold: %0d cycles left stage0 early, want 0", bad);
    end
    tests_run++;
    if (waited !== hold_len - 1) begin
      tests_failed++;
      $display("FAIL drain_wait: waited %0d, want %0d", waited, hold_len - 1);
    end
    step();
    tests_run++;
    if ({bf_valid, stage, bf_idx} !== {1'b1, 2'd1, 4'd0}) begin
      tests_failed++;
      $display("FAIL drain_release: valid=%0d stage=%0d b=%0d, want 1 1 0", bf_valid, stage, bf_idx);
    end
    finish_run(-1);
    hold_idx = -1;
  endtask

  task automatic test_errors();
    int n;
    wb_valid = 1'b1;
    step();
    tests_run++;
    if (err !== 1'b1) begin
      tests_failed++;
      $display("FAIL idle_wb_err: got %0d, want 1", err);
    end
    repeat (5) step();
    tests_run++;
    if (err !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_sticky: got %0d, want 1", err);
    end
    auto_wb = 1'b0;
    new_run();
    tests_run++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_clears_err: err=%0d busy=%0d, want 0 1", err, busy);
    end
    for (int i = 0; i < 100 && hs_cnt < 16; i++) step();
    n = 0;
    while (busy && n < 400) begin
      step();
      n++;
    end
    tests_run++;
    if (n !== int'(DRAIN_TIMEOUT)) begin
      tests_failed++;
      $display("FAIL timeout_len: drained %0d cycles, want %0d", n, DRAIN_TIMEOUT);
    end
    tests_run++;
    if (err !== 1'b1 || done_cnt !== 0) begin
      tests_failed++;
      $display("FAIL timeout_err: err=%0d done=%0d, want 1 0", err, done_cnt);
    end
    auto_wb = 1'b1;
  endtask

  task automatic test_abort();
    bit found;
    found = 1'b0;
    new_run();
    for (int i = 0; i < 300; i++) begin
      if (bf_valid && stage == 2'd2 && bf_idx == 4'd15) begin
        found = 1'b1;
        break;
      end
      step();
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL reach_s2b15: stage=%0d b=%0d, want 2 15", stage, bf_idx);
    end
    abort    = 1'b1;
    bf_ready = 1'b1;
    step();
    abort    = 1'b0;
    wb_q.delete();
    wb_valid = 1'b0;
    tests_run++;
    if ({busy, bf_valid, done, err, stage, bf_idx} !== 10'd0) begin
      tests_failed++;
      $display("FAIL abort_idle: busy=%0d valid=%0d done=%0d err=%0d stage=%0d b=%0d, want all 0",
               busy, bf_valid, done, err, stage, bf_idx);
    end
    repeat (3) step();
    tests_run++;
    if (done_cnt !== 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_no_done: done=%0d busy=%0d, want 0 0", done_cnt, busy);
    end
    new_run();
    finish_run(NOMINAL_BUSY);
  endtask

  initial begin
    test_reset();
    test_reset_mid_issue();
    test_nominal();
    test_backpressure();
    test_drain_gating();
    test_errors();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fft64_stage_sequencer.md
Name: fft64_stage_sequencer

Overview:
Control sequencer for the 64-point radix-4 FFT butterfly datapath. It runs 3 stages of 16 butterflies each. For each butterfly it issues 4 data-memory addresses and 3 twiddle-ROM indices into the 64-entry W64 table (layout: entry 0 = 1; entries 16+k, 32+k and 48+k = W64^k, W64^2k and W64^3k, for k=0..15). Between stages it waits for all 16 writebacks, so in-place stage data is never read before it is written.

Parameters:
DRAIN_TIMEOUT, 255, max cycles spent in DRAIN waiting for writebacks before err is raised.
WB_CNT_W, 5, width of the outstanding-writeback counter; must hold the value 16.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin a transform; sampled only in IDLE
abort  input  1  return to IDLE next cycle from any state; no done pulse
bf_valid  output  1  butterfly command valid
bf_ready  input  1  datapath accepts command when bf_valid&&bf_ready
stage  output  2  current stage 0..2
bf_idx  output  4  butterfly index b within stage, 0..15
addr0..addr3  output  6 each  data addresses of the 4 butterfly legs
tw1..tw3  output  6 each  ROM indices for legs 1..3; leg 0 is always unit twiddle
wb_valid  input  1  one butterfly result written back (pulse per butterfly)
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse when a transform completes
err  output  1  sticky; cleared only by rst or by the next accepted start

Behaviour:
- Reset (async): state=IDLE; bf_valid=0, stage=0, bf_idx=0, all addr/tw=0, busy=0, done=0, err=0; counters=0.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on start=1, clear err and go to ISSUE with stage=0, b=0.
- ISSUE: bf_valid=1. Outputs are combinational from registered (stage, b) and stay stable while bf_ready=0.
  - On handshake: b increments and the issued counter increments.
  - On handshake with b==15: bf_valid drops next cycle and state goes to DRAIN.
- DRAIN: bf_valid=0. Wait until wb_count==16.
  - If stage<2: stage++, b=0, wb_count=0, return to ISSUE.
  - If stage==2: go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. A start asserted during DONE is ignored.
- Writeback counting: wb_valid increments wb_count in every non-IDLE state, so writebacks that overlap ISSUE are counted.
  - A wb_valid arriving when wb_count==16, or in IDLE, sets err. It does not change state and the count saturates at 16.
- Timeout: a DRAIN_TIMEOUT counter resets on entering DRAIN and on each wb_valid. If it expires: set err, go to IDLE, no done.
- Address generation (b = bf_idx, g = b>>2, j = b&3):
  - stage0: addr = b, b+16, b+32, b+48; tw1..tw3 = 16+b, 32+b, 48+b.
  - stage1: base = 16g; addr = base+j, +4, +8, +12; tw1..tw3 = 16+4j, 32+4j, 48+4j.
  - stage2: addr = 4b, 4b+1, 4b+2, 4b+3; tw1..tw3 = 0.
  - All sums are 6-bit with no overflow by construction.
- Abort: has priority over every other event in the same cycle. Next cycle state=IDLE, bf_valid=0, counters cleared, err unchanged.
- Throughput: with bf_ready held high, ISSUE lasts exactly 16 cycles per stage. Minimum transform latency is 3×(16 + drain) + 1 cycles.

Test Plan:
- Reset mid-ISSUE (stage1, b=5): assert rst → all outputs go to 0 immediately (async); after release, state is IDLE and start is required to run again.
- Nominal run: start with bf_ready=1 and wb_valid returned 2 cycles after each handshake → 48 handshakes; at stage0 b=5 expect addr=5,21,37,53 and tw=21,37,53; at stage1 b=6 expect addr=18,22,26,30 and tw=24,40,56; at stage2 b=7 expect addr=28..31 and tw=0,0,0; single done pulse; busy falls the same cycle done falls.
- Backpressure: bf_ready toggles randomly → addr/tw/bf_idx stay stable while bf_valid&&!bf_ready; no butterfly is skipped or duplicated (scoreboard of 48 (stage,b) pairs).
- Drain gating: withhold the 16th writeback of stage0 for 50 cycles → stage stays 0 and bf_valid stays 0 until it arrives, then stage1 b=0 issues the next cycle.
- Errors: wb_valid while IDLE → err=1 and it persists; a new start clears it. In DRAIN send no wb for 256 cycles → err=1, return to IDLE, no done.
- Abort with simultaneous handshake at stage2 b=15 → next cycle IDLE, no done, wb_count=0; a subsequent start runs a full clean transform.
